// File: rtl/stream_arb2.sv
// Packet-level round-robin arbiter sharing one AXI-stream sink between two sources.
// The output is registered, tagged with its source index, and packets are counted per source.
module stream_arb2 #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [DATA_WIDTH-1:0]  in0_data,
    input  logic                   in0_last,
    input  logic                   in0_valid,
    output logic                   in0_ready,
    input  logic [DATA_WIDTH-1:0]  in1_data,
    input  logic                   in1_last,
    input  logic                   in1_valid,
    output logic                   in1_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic                   out_src,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] num_packets0,
    output logic [COUNT_WIDTH-1:0] num_packets1
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t                 state_q;
    logic                   prio_q;
    logic                   outValid_q;
    logic                   outLast_q;
    logic                   outSrc_q;
    logic [DATA_WIDTH-1:0]  outData_q;
    logic [COUNT_WIDTH-1:0] count0_q;
    logic [COUNT_WIDTH-1:0] count1_q;
    logic [COUNT_WIDTH-1:0] count0_d;
    logic [COUNT_WIDTH-1:0] count1_d;

    logic outFree;
    logic take0;
    logic take1;

    // The output slot is free when empty or being drained this cycle, giving one beat per cycle.
    assign outFree   = ~outValid_q | out_ready;
    assign in0_ready = (state_q == GNT0) & outFree;
    assign in1_ready = (state_q == GNT1) & outFree;
    assign take0     = in0_valid & in0_ready;
    assign take1     = in1_valid & in1_ready;

    assign count0_d  = count0_q + COUNT_WIDTH'(1);
    assign count1_d  = count1_q + COUNT_WIDTH'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            outSrc_q   <= 1'b0;
            outData_q  <= '0;
            count0_q   <= '0;
            count1_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        if (in0_valid && (!in1_valid || !prio_q)) begin
                            state_q <= GNT0;
                        end else if (in1_valid) begin
                            state_q <= GNT1;
                        end
                    end
                end
                GNT0: begin
                    if (take0 && in0_last) begin
                        state_q  <= IDLE;
                        prio_q   <= 1'b1;
                        count0_q <= count0_d;
                    end
                end
                GNT1: begin
                    if (take1 && in1_last) begin
                        state_q  <= IDLE;
                        prio_q   <= 1'b0;
                        count1_q <= count1_d;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A new beat overwrites the slot; otherwise a consumed beat empties it.
            if (take0 || take1) begin
                outValid_q <= 1'b1;
                outData_q  <= take1 ? in1_data : in0_data;
                outLast_q  <= take1 ? in1_last : in0_last;
                outSrc_q   <= take1;
            end else if (out_ready) begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign out_data     = outData_q;
    assign out_last     = outLast_q;
    assign out_src      = outSrc_q;
    assign out_valid    = outValid_q;
    assign num_packets0 = count0_q;
    assign num_packets1 = count1_q;

endmodule

// File: tb/tb_stream_arb2.sv
// Self-checking bench for stream_arb2: directed scenarios plus random traffic,
// checked every cycle against a behavioural arbiter model and a per-source beat scoreboard.
module tb_stream_arb2;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic [31:0] in0_data = '0;
    logic        in0_last = 1'b0;
    logic        in0_valid = 1'b0;
    logic        in0_ready;
    logic [31:0] in1_data = '0;
    logic        in1_last = 1'b0;
    logic        in1_valid = 1'b0;
    logic        in1_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_src;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] num_packets0;
    logic [31:0] num_packets1;

    logic        reset2_n = 1'b0;
    logic        d2In1Valid = 1'b1;
    logic        d2In0Ready;
    logic        d2In1Ready;
    logic [31:0] d2OutData;
    logic        d2OutLast;
    logic        d2OutSrc;
    logic        d2OutValid;
    logic [1:0]  d2Num0;
    logic [1:0]  d2Num1;

    int compared = 0;
    int mismatched = 0;

    // Stimulus and scoreboard state
    beat_t       planQ[2][$];
    beat_t       sbQ[2][$];
    bit          hv[2];
    logic [31:0] hd[2];
    bit          hl[2];
    bit          inPkt[2];
    int          genPkts[2];
    int          prob[2];
    int          mode;
    bit          outReadyD;
    bit          enableD;
    int          srcLog[$];
    logic [31:0] dataLog[$];

    // Behavioural arbiter model
    int          mOwner;
    int          mPref;
    bit          mOutValid;
    logic [31:0] mOutData;
    bit          mOutLast;
    int          mOutSrc;
    logic [31:0] mPkts[2];
    bit          mTake[2];

    always #5 clock = ~clock;

    stream_arb2 #(.DATA_WIDTH(32), .COUNT_WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .in0_data(in0_data), .in0_last(in0_last), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_last(in1_last), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_last(out_last), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready), .num_packets0(num_packets0), .num_packets1(num_packets1)
    );

    stream_arb2 #(.DATA_WIDTH(32), .COUNT_WIDTH(2)) dut2 (
        .clock(clock), .reset_n(reset2_n), .enable(1'b1),
        .in0_data(32'h0), .in0_last(1'b0), .in0_valid(1'b0), .in0_ready(d2In0Ready),
        .in1_data(32'hABCD0001), .in1_last(1'b1), .in1_valid(d2In1Valid), .in1_ready(d2In1Ready),
        .out_data(d2OutData), .out_last(d2OutLast), .out_src(d2OutSrc), .out_valid(d2OutValid),
        .out_ready(1'b1), .num_packets0(d2Num0), .num_packets1(d2Num1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic planBeat(input int x, input logic [31:0] d, input bit l);
        beat_t b;
        b.data = d;
        b.last = l;
        planQ[x].push_back(b);
    endtask

    task automatic modelReset();
        mOwner    = -1;
        mPref     = 0;
        mOutValid = 0;
        mOutData  = '0;
        mOutLast  = 0;
        mOutSrc   = 0;
        for (int x = 0; x < 2; x++) begin
            mPkts[x] = '0;
            mTake[x] = 0;
        end
    endtask

    // Advances the model across the coming rising edge using the inputs now on the pins.
    task automatic modelStep();
        int prevOwner;
        int w;
        bit rdy;
        prevOwner = mOwner;
        for (int x = 0; x < 2; x++) begin
            rdy = (mOwner == x) && (!mOutValid || outReadyD);
            mTake[x] = hv[x] && rdy;
        end
        if (mTake[0] || mTake[1]) begin
            w = mTake[1] ? 1 : 0;
            mOutValid = 1;
            mOutData  = hd[w];
            mOutLast  = hl[w];
            mOutSrc   = w;
            if (hl[w]) begin
                mPkts[w] = mPkts[w] + 1;
                mPref    = 1 - w;
                mOwner   = -1;
            end
        end else if (mOutValid && outReadyD) begin
            mOutValid = 0;
        end
        if (prevOwner == -1 && enableD && (hv[0] || hv[1])) begin
            mOwner = (hv[0] && hv[1]) ? mPref : (hv[0] ? 0 : 1);
        end
    endtask

    task automatic applyPins();
        in0_valid = hv[0];
        in0_data  = hd[0];
        in0_last  = hl[0];
        in1_valid = hv[1];
        in1_data  = hd[1];
        in1_last  = hl[1];
        out_ready = outReadyD;
        enable    = enableD;
    endtask

    task automatic flushBench();
        for (int x = 0; x < 2; x++) begin
            planQ[x].delete();
            sbQ[x].delete();
            hv[x]      = 0;
            hd[x]      = '0;
            hl[x]      = 0;
            inPkt[x]   = 0;
            genPkts[x] = 0;
        end
        modelReset();
        applyPins();
    endtask

    task automatic applyStimulus();
        beat_t b;
        bit    go;
        if (mode == 1) begin
            outReadyD = ($urandom_range(3) != 0);
            enableD   = ($urandom_range(9) != 0);
        end else if (mode == 2) begin
            outReadyD = 1;
            enableD   = 1;
        end
        for (int x = 0; x < 2; x++) begin
            if (mTake[x]) hv[x] = 0;
            if (!hv[x]) begin
                go = 0;
                if (planQ[x].size() > 0) begin
                    b  = planQ[x].pop_front();
                    go = 1;
                end else if (mode == 1 && $urandom_range(99) < prob[x]) begin
                    b.data = $urandom;
                    b.last = ($urandom_range(2) == 0);
                    go     = 1;
                end else if (mode == 2 && inPkt[x]) begin
                    b.data = $urandom;
                    b.last = 1;
                    go     = 1;
                end
                if (go) begin
                    hv[x] = 1;
                    hd[x] = b.data;
                    hl[x] = b.last;
                    inPkt[x] = !b.last;
                    if (b.last) genPkts[x]++;
                    sbQ[x].push_back(b);
                end
            end
        end
        applyPins();
    endtask

    task automatic checkCycle();
        beat_t b;
        int    s;
        checkOutput("in0Ready", in0_ready, (mOwner == 0) && (!mOutValid || outReadyD));
        checkOutput("in1Ready", in1_ready, (mOwner == 1) && (!mOutValid || outReadyD));
        checkOutput("outValid", out_valid, mOutValid);
        checkOutput("outData", out_data, mOutData);
        checkOutput("outLast", out_last, mOutLast);
        checkOutput("outSrc", out_src, mOutSrc);
        checkOutput("numPackets0", num_packets0, mPkts[0]);
        checkOutput("numPackets1", num_packets1, mPkts[1]);
        // Every consumed output beat must be the oldest unsent beat of its source.
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            s = (out_src === 1'b1) ? 1 : 0;
            dataLog.push_back(out_data);
            if (out_last) srcLog.push_back(s);
            checkOutput("sbHasBeat", sbQ[s].size() > 0, 1);
            if (sbQ[s].size() > 0) begin
                b = sbQ[s].pop_front();
                checkOutput("sbData", out_data, b.data);
                checkOutput("sbLast", out_last, b.last);
            end
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            applyStimulus();
            @(negedge clock);
            checkCycle();
            modelStep();
        end
    endtask

    task automatic resetChecks(input string tag);
        checkOutput({tag, "OutValid"}, out_valid, 0);
        checkOutput({tag, "OutData"}, out_data, 0);
        checkOutput({tag, "OutLast"}, out_last, 0);
        checkOutput({tag, "OutSrc"}, out_src, 0);
        checkOutput({tag, "In0Ready"}, in0_ready, 0);
        checkOutput({tag, "In1Ready"}, in1_ready, 0);
        checkOutput({tag, "Num0"}, num_packets0, 0);
        checkOutput({tag, "Num1"}, num_packets1, 0);
    endtask

    // Asserts reset between clock edges, checks the immediate effect, releases at a falling edge.
    task automatic resetPulse();
        #2;
        reset_n = 1'b0;
        #1;
        resetChecks("midReset");
        flushBench();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        modelStep();
    endtask

    task automatic checkLogs(input string tag, input int expSrc[$], input logic [31:0] expData[$]);
        if (expSrc.size() > 0) begin
            checkOutput({tag, "SrcCount"}, srcLog.size(), expSrc.size());
            foreach (expSrc[i])
                checkOutput({tag, "Src"}, (i < srcLog.size()) ? srcLog[i] : 99, expSrc[i]);
        end
        if (expData.size() > 0) begin
            checkOutput({tag, "BeatCount"}, dataLog.size(), expData.size());
            foreach (expData[i])
                checkOutput({tag, "Data"}, (i < dataLog.size()) ? dataLog[i] : 32'hDEADBEEF, expData[i]);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          expWrap[5] = '{1, 2, 3, 0, 1};
        int          k;
        logic [1:0]  prev;
        int          noSrc[$];
        int          order[$];
        logic [31:0] noData[$];
        logic [31:0] expData[$];

        mode      = 0;
        outReadyD = 1;
        enableD   = 1;
        flushBench();

        // Narrow counter wraps on a second instance while the main one sits in reset.
        @(negedge clock);
        reset2_n = 1'b1;
        resetChecks("reset");
        prev = 2'd0;
        k    = 0;
        for (int i = 0; i < 40 && k < 5; i++) begin
            @(negedge clock);
            if (d2Num1 != prev) begin
                checkOutput("wrapCount", d2Num1, expWrap[k]);
                prev = d2Num1;
                k++;
            end
        end
        checkOutput("wrapSeen", k, 5);
        d2In1Valid = 1'b0;

        reset_n = 1'b1;
        #1;
        modelStep();

        $display("[TB] both sources contend from reset");
        srcLog.delete();
        dataLog.delete();
        for (int p = 0; p < 2; p++) begin
            planBeat(0, 32'h10 + 32'(p * 2), 0);
            planBeat(0, 32'h11 + 32'(p * 2), 1);
            planBeat(1, 32'h20 + 32'(p * 2), 0);
            planBeat(1, 32'h21 + 32'(p * 2), 1);
        end
        runCycles(25);
        order = '{0, 1, 0, 1};
        checkLogs("rrOrder", order, noData);
        checkOutput("rrNum0", num_packets0, 2);
        checkOutput("rrNum1", num_packets1, 2);

        $display("[TB] single source three-beat packet");
        srcLog.delete();
        dataLog.delete();
        planBeat(0, 32'h04030201, 0);
        planBeat(0, 32'h05040302, 0);
        planBeat(0, 32'h06050403, 1);
        runCycles(10);
        expData = '{32'h04030201, 32'h05040302, 32'h06050403};
        order = '{0};
        checkLogs("threeBeat", order, expData);
        checkOutput("threeBeatNum0", num_packets0, 3);

        $display("[TB] backpressure mid-packet");
        srcLog.delete();
        dataLog.delete();
        expData.delete();
        for (int i = 0; i < 6; i++) begin
            planBeat(0, 32'h100 + 32'(i), i == 5);
            expData.push_back(32'h100 + 32'(i));
        end
        runCycles(3);
        outReadyD = 0;
        runCycles(5);
        outReadyD = 1;
        runCycles(12);
        checkLogs("backpressure", noSrc, expData);
        checkOutput("backpressureNum0", num_packets0, 4);

        $display("[TB] enable dropped during a packet");
        for (int i = 0; i < 4; i++) planBeat(0, 32'h200 + 32'(i), i == 3);
        planBeat(0, 32'h300, 1);
        for (int i = 0; i < 10 && !mTake[0]; i++) runCycles(1);
        checkOutput("firstBeatWait", mTake[0], 1);
        enableD = 0;
        planBeat(1, 32'h400, 1);
        runCycles(14);
        checkOutput("disabledNum0", num_packets0, 5);
        checkOutput("disabledNum1", num_packets1, 2);
        enableD = 1;
        runCycles(12);
        checkOutput("reenabledNum0", num_packets0, 6);
        checkOutput("reenabledNum1", num_packets1, 3);

        $display("[TB] asynchronous reset mid-packet");
        for (int i = 0; i < 5; i++) planBeat(0, 32'h500 + 32'(i), i == 4);
        runCycles(4);
        resetPulse();
        srcLog.delete();
        dataLog.delete();
        planBeat(0, 32'h600, 1);
        planBeat(1, 32'h700, 1);
        runCycles(10);
        order = '{0, 1};
        checkLogs("afterReset", order, noData);
        checkOutput("afterResetNum0", num_packets0, 1);
        checkOutput("afterResetNum1", num_packets1, 1);

        $display("[TB] random traffic");
        mode    = 1;
        prob[0] = $urandom_range(90, 30);
        prob[1] = $urandom_range(90, 30);
        runCycles(600);
        mode = 2;
        runCycles(150);
        checkOutput("drain0", sbQ[0].size(), 0);
        checkOutput("drain1", sbQ[1].size(), 0);
        checkOutput("totalPackets0", num_packets0, genPkts[0]);
        checkOutput("totalPackets1", num_packets1, genPkts[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stream_arb2.md
Name: stream_arb2

Overview:
- Packet-level round-robin arbiter that shares one AXI-stream sink between two AXI-stream sources, for example two stream data generators in a test bench, or two data FIFOs in the DMA path.
- A grant is held from the first beat of a packet until its beat with last set has been accepted, so packets are never interleaved.
- The output passes through one register stage and tags each beat with its source index.
- Per-source packet counters are provided for bench checks and status readout.

Parameters:
DATA_WIDTH, 32, width of the data bus on both inputs and the output
COUNT_WIDTH, 32, width of each per-source packet counter

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  1 = new grants allowed; 0 = no new grant (a packet in progress completes)
in0_data  input  DATA_WIDTH  source 0 data
in0_last  input  1  source 0 end-of-packet
in0_valid  input  1  source 0 valid
in0_ready  output  1  source 0 ready
in1_data  input  DATA_WIDTH  source 1 data
in1_last  input  1  source 1 end-of-packet
in1_valid  input  1  source 1 valid
in1_ready  output  1  source 1 ready
out_data  output  DATA_WIDTH  registered output data
out_last  output  1  registered end-of-packet
out_src  output  1  index of the source that produced the current output beat
out_valid  output  1  registered valid
out_ready  input  1  downstream ready
num_packets0  output  COUNT_WIDTH  packets from source 0 accepted at input (last beat taken)
num_packets1  output  COUNT_WIDTH  packets from source 1 accepted at input

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - state = IDLE; priority pointer prio = 0 (source 0 preferred).
  - out_valid = 0, out_data = 0, out_last = 0, out_src = 0.
  - Both counters = 0; in0_ready = in1_ready = 0.
  - Reset mid-packet drops the output beat and the grant immediately; no partial packet is resumed afterwards.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - If enable = 0 or neither input is valid, stay in IDLE.
  - If exactly one of in0_valid / in1_valid is 1, go to GNTx for that source on the next edge.
  - If both are valid, go to GNT[prio].
  - No input is ready while in IDLE, which gives 1 cycle of arbitration latency.
- GNTx:
  - inx_ready = (~out_valid | out_ready). The other input's ready = 0.
  - The ready path from out_ready to inx_ready is combinational.
  - On an input handshake (inx_valid & inx_ready), the output register loads data/last, out_src = x, and out_valid = 1.
  - If that beat has last = 1: counter x increments, prio is set to ~x, and the next state is IDLE.
  - enable is ignored inside GNTx.
- Output register:
  - If out_valid & out_ready and no new input handshake happens in the same cycle, out_valid goes to 0.
  - A simultaneous output handshake and input handshake replaces the beat, so throughput is one beat per cycle within a packet.
  - Packets are separated by at least one IDLE cycle at the input side.
  - out_* hold steady while out_valid = 1 and out_ready = 0 (AXI-stream rule).
- Single-beat packet (last on the first beat): GNTx lasts one handshake, then returns to IDLE.
- Counters wrap modulo 2^COUNT_WIDTH with no saturation.
- Input valid deasserting mid-packet: the grant is held and the block waits; there is no timeout.

Test Plan:
- Only source 0 active, 3-beat packet 0x04030201, 0x05040302, 0x06050403 with last on the third beat, out_ready = 1 → output shows the same 3 beats, out_src = 0, out_last only on the third; num_packets0 = 1; in0_ready first high 1 cycle after in0_valid.
- Both sources valid from reset, each sending 2-beat packets, 4 packets total → output source order 0,1,0,1; no interleaving within a packet; num_packets0 = num_packets1 = 2.
- Backpressure: out_ready = 0 for 5 cycles mid-packet → out_data/out_last/out_src stable; the granted in_ready = 0 throughout; no beat lost or duplicated after out_ready returns to 1.
- enable = 0 raised after the first beat of a 4-beat packet → that packet completes all 4 beats; no new grant while enable = 0 even with both valid; arbitration resumes 1 cycle after enable = 1.
- Assert reset_n = 0 asynchronously (between edges) mid-packet → out_valid, the ready outputs and the counters go to 0 immediately; after release, source 0 wins when both are valid.
- COUNT_WIDTH = 2, 5 single-beat packets on source 1 → num_packets1 sequence 1,2,3,0,1.
